// File: rtl/nco_phase_accumulator_if.sv
// Control/status bundle for the NCO phase accumulator.
//   master : drives enable, sync, FTW and phase-offset loads; observes phase.
//   slave  : the accumulator; returns ftw_pending, phase_out, phase_valid, wrap.
interface nco_phase_accumulator_if #(
  parameter int unsigned ACC_W = 32
);
  logic             en;
  logic             sync;
  logic [ACC_W-1:0] ftw_in;
  logic             ftw_load;
  logic [ACC_W-1:0] pofs_in;
  logic             pofs_load;
  logic             ftw_pending;
  logic [ACC_W-1:0] phase_out;
  logic             phase_valid;
  logic             wrap;

  modport master (
    output en, sync, ftw_in, ftw_load, pofs_in, pofs_load,
    input  ftw_pending, phase_out, phase_valid, wrap
  );

  modport slave (
    input  en, sync, ftw_in, ftw_load, pofs_in, pofs_load,
    output ftw_pending, phase_out, phase_valid, wrap
  );
endinterface

// File: rtl/nco_phase_accumulator.sv
// NCO phase accumulator, two-stage pipeline.
//   Stage 1: acc += active FTW when enabled (sync clears it), carry captured.
//   Stage 2: phase_out = acc + active phase offset (mod 2^ACC_W).
// The FTW is double-buffered: loads land in a pending register and commit
// either on the next edge or, with UPDATE_ON_WRAP, on the next carry-out
// (or sync) so the frequency change is phase-continuous.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - slave side of nco_phase_accumulator_if (controls in, phase out)
module nco_phase_accumulator #(
  parameter int unsigned      ACC_W          = 32,
  parameter logic [ACC_W-1:0] FTW_RESET      = '0,
  parameter bit               UPDATE_ON_WRAP = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  nco_phase_accumulator_if.slave  bus
);

  logic [ACC_W-1:0] acc_q,      acc_d;
  logic             s1_carry_q, s1_carry_d;
  logic             s1_en_q,    s1_en_d;
  logic [ACC_W-1:0] ftw_act_q,  ftw_act_d;
  logic [ACC_W-1:0] ftw_pend_q, ftw_pend_d;
  logic             pending_q,  pending_d;
  logic [ACC_W-1:0] pofs_q,     pofs_d;
  logic [ACC_W-1:0] phase_q,    phase_d;
  logic             valid_q,    valid_d;
  logic             wrap_q,     wrap_d;

  logic [ACC_W:0]   sum;
  logic             commit;

  assign sum = {1'b0, acc_q} + {1'b0, ftw_act_q};

  always_comb begin
    acc_d      = acc_q;
    s1_carry_d = 1'b0;
    s1_en_d    = bus.en;
    if (bus.sync) begin
      acc_d = '0;
    end else if (bus.en) begin
      acc_d      = sum[ACC_W-1:0];
      s1_carry_d = sum[ACC_W];
    end

    // Wrap mode: commit on the carrying addition (which itself still used the
    // old FTW), or on sync so a zero FTW cannot stall the update forever.
    if (UPDATE_ON_WRAP)
      commit = pending_q && (bus.sync || (bus.en && sum[ACC_W]));
    else
      commit = pending_q;

    ftw_act_d  = commit ? ftw_pend_q : ftw_act_q;
    ftw_pend_d = bus.ftw_load ? bus.ftw_in : ftw_pend_q;
    // A load coinciding with a commit keeps the flag set for the newer word.
    if (bus.ftw_load)   pending_d = 1'b1;
    else if (commit)    pending_d = 1'b0;
    else                pending_d = pending_q;

    pofs_d  = bus.pofs_load ? bus.pofs_in : pofs_q;

    // Stage 2 runs every edge so offset changes show up even while held.
    phase_d = acc_q + pofs_q;
    valid_d = s1_en_q;
    wrap_d  = s1_carry_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      s1_carry_q <= 1'b0;
      s1_en_q    <= 1'b0;
      ftw_act_q  <= FTW_RESET;
      ftw_pend_q <= '0;
      pending_q  <= 1'b0;
      pofs_q     <= '0;
      phase_q    <= '0;
      valid_q    <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      s1_carry_q <= s1_carry_d;
      s1_en_q    <= s1_en_d;
      ftw_act_q  <= ftw_act_d;
      ftw_pend_q <= ftw_pend_d;
      pending_q  <= pending_d;
      pofs_q     <= pofs_d;
      phase_q    <= phase_d;
      valid_q    <= valid_d;
      wrap_q     <= wrap_d;
    end
  end

  assign bus.ftw_pending = pending_q;
  assign bus.phase_out   = phase_q;
  assign bus.phase_valid = valid_q;
  assign bus.wrap        = wrap_q;

endmodule

// File: tb/tb_nco_phase_accumulator.sv
module tb_nco_phase_accumulator;
  localparam int unsigned W = 32;
  localparam logic [W-1:0] P = 32'h0001_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  nco_phase_accumulator_if #(.ACC_W(W)) a ();
  nco_phase_accumulator_if #(.ACC_W(W)) b ();

  nco_phase_accumulator #(.ACC_W(W), .FTW_RESET('0), .UPDATE_ON_WRAP(1'b0)) dut_a (
    .clk(clk), .rst(rst), .bus(a)
  );
  nco_phase_accumulator #(.ACC_W(W), .FTW_RESET(32'h4000_0000), .UPDATE_ON_WRAP(1'b1)) dut_b (
    .clk(clk), .rst(rst), .bus(b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    {a.en, a.sync, a.ftw_load, a.pofs_load} = '0;
    a.ftw_in = '0; a.pofs_in = '0;
    {b.en, b.sync, b.ftw_load, b.pofs_load} = '0;
    b.ftw_in = '0; b.pofs_in = '0;

    // reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_phase", a.phase_out, 0);
    chk("rst_valid", a.phase_valid, 0);
    chk("rst_wrap", a.wrap, 0);
    chk("rst_pend", a.ftw_pending, 0);

    // FTW = 65536 ramp
    a.ftw_in = 32'd65536; a.ftw_load = 1'b1; tick();
    chk("load_pend", a.ftw_pending, 1);
    a.ftw_load = 1'b0; tick();
    chk("commit_pend", a.ftw_pending, 0);
    a.en = 1'b1; tick();
    chk("ramp_first_invalid", a.phase_valid, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("ramp_phase", a.phase_out, 65536 * i);
      chk("ramp_upper16", a.phase_out[31:16], i);
      chk("ramp_valid", a.phase_valid, 1);
    end

    // FTW = 0x8000_0000 wrap
    a.en = 1'b0; a.sync = 1'b1; a.ftw_in = 32'h8000_0000; a.ftw_load = 1'b1; tick();
    a.sync = 1'b0; a.ftw_load = 1'b0; tick();
    a.en = 1'b1; tick(); tick();
    chk("half_p0", a.phase_out, 32'h8000_0000);
    chk("half_w0", a.wrap, 0);
    tick();
    chk("half_p1", a.phase_out, 32'h0000_0000);
    chk("half_w1", a.wrap, 1);
    tick();
    chk("half_p2", a.phase_out, 32'h8000_0000);
    chk("half_w2", a.wrap, 0);

    // FTW = 100, offset load, sync
    a.en = 1'b0; a.sync = 1'b1; a.ftw_in = 32'd100; a.ftw_load = 1'b1; tick();
    a.sync = 1'b0; a.ftw_load = 1'b0; tick();
    a.en = 1'b1; tick(); tick(); tick(); tick();
    chk("ftw100_p", a.phase_out, 300);
    a.en = 1'b0; a.pofs_in = P; a.pofs_load = 1'b1; tick();
    chk("pofs_not_yet", a.phase_out, 400);
    a.pofs_load = 1'b0; tick();
    chk("pofs_applied", a.phase_out, P + 400);
    a.sync = 1'b1; tick();
    a.sync = 1'b0; tick();
    chk("sync_phase", a.phase_out, P);
    chk("sync_valid", a.phase_valid, 0);

    // enable toggle 1,0,0,1 then 0 (acc starts at 0, FTW 100, offset P)
    a.en = 1'b1; tick();
    chk("tog1_p", a.phase_out, P);
    a.en = 1'b0; tick();
    chk("tog2_p", a.phase_out, P + 100);
    chk("tog2_v", a.phase_valid, 1);
    tick();
    chk("tog3_p", a.phase_out, P + 100);
    chk("tog3_v", a.phase_valid, 0);
    chk("tog3_w", a.wrap, 0);
    a.en = 1'b1; tick();
    chk("tog4_p", a.phase_out, P + 100);
    chk("tog4_v", a.phase_valid, 0);
    a.en = 1'b0; tick();
    chk("tog5_p", a.phase_out, P + 200);
    chk("tog5_v", a.phase_valid, 1);

    // back-to-back loads 10 then 20
    a.sync = 1'b1; a.ftw_in = 32'd10; a.ftw_load = 1'b1; tick();
    a.sync = 1'b0; a.ftw_in = 32'd20; tick();
    chk("b2b_pend", a.ftw_pending, 1);
    a.ftw_load = 1'b0; a.en = 1'b1; tick();
    chk("b2b_pend_clr", a.ftw_pending, 0);
    tick();
    chk("b2b_p10", a.phase_out, P + 10);
    a.en = 1'b0; tick();
    chk("b2b_p30", a.phase_out, P + 30);

    // reset mid-operation discards pending load and clears pipeline
    a.en = 1'b1; a.ftw_in = 32'd555; a.ftw_load = 1'b1; rst = 1'b1; tick();
    chk("mrst_pend", a.ftw_pending, 0);
    chk("mrst_valid", a.phase_valid, 0);
    chk("mrst_phase", a.phase_out, 0);
    rst = 1'b0; a.en = 1'b0; a.ftw_load = 1'b0; tick();
    chk("mrst_after", a.phase_out, 0);

    // phase-continuous update on wrap (dut_b, FTW_RESET 0x4000_0000)
    b.en = 1'b1; tick();
    b.ftw_in = 32'h1000_0000; b.ftw_load = 1'b1; tick();
    chk("uow_pend_80", b.ftw_pending, 1);
    b.ftw_load = 1'b0; tick();
    chk("uow_pend_C0", b.ftw_pending, 1);
    chk("uow_p80", b.phase_out, 32'h8000_0000);
    tick();
    chk("uow_commit", b.ftw_pending, 0);
    chk("uow_pC0", b.phase_out, 32'hC000_0000);
    tick();
    chk("uow_p0", b.phase_out, 0);
    chk("uow_w1", b.wrap, 1);
    tick();
    chk("uow_p10", b.phase_out, 32'h1000_0000);
    chk("uow_w0", b.wrap, 0);

    // sync commits a pending word without a carry
    b.en = 1'b0; b.ftw_in = '0; b.ftw_load = 1'b1; tick();
    b.ftw_load = 1'b0; tick();
    chk("uow_hold_pend", b.ftw_pending, 1);
    b.sync = 1'b1; tick();
    b.sync = 1'b0;
    chk("uow_sync_commit", b.ftw_pending, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/nco_phase_accumulator.md
Name: nco_phase_accumulator

Overview:
- Phase accumulator at the front of the NCO datapath.
- Each enabled cycle it adds a frequency tuning word (FTW) to a 32-bit accumulator, then adds a phase offset.
- Its 32-bit phase output feeds Quantizer32to16, which keeps the upper 16 bits for the phase-to-amplitude stage.
- Supports double-buffered FTW updates, optionally phase-continuous (committed on wrap), plus a phase-clear sync input.

Parameters:
- ACC_W, 32, accumulator, FTW, offset and phase output width.
- FTW_RESET, 0, active FTW value after reset.
- UPDATE_ON_WRAP, 0. 0 = pending FTW commits on the next edge. 1 = pending FTW commits only on an edge whose accumulation carries out.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  accumulate enable; accumulator holds when 0.
- sync  in  1  phase clear: accumulator forced to 0 at the next edge.
- ftw_in  in  ACC_W  new tuning word.
- ftw_load  in  1  capture ftw_in into the pending register.
- pofs_in  in  ACC_W  new phase offset.
- pofs_load  in  1  capture pofs_in into the active offset.
- ftw_pending  out  1  pending FTW not yet committed.
- phase_out  out  ACC_W  registered phase = accumulator + offset, mod 2^ACC_W; goes to Quantizer32to16_in.
- phase_valid  out  1  phase_out carries a new enabled sample.
- wrap  out  1  accumulator carry-out, aligned with phase_out.

Behaviour:
- One clock; reset is synchronous and active-high on rst. rst has priority over every other input.
- Reset values:
  - acc = 0, ftw_act = FTW_RESET, ftw_pend = 0, ftw_pending = 0, pofs_act = 0.
  - Stage-1 flags = 0.
  - phase_out = 0, phase_valid = 0, wrap = 0.
- Stage 1 (accumulate), priority sync > en:
  - sync=1: acc <= 0, carry_d <= 0.
  - else en=1: {c, acc} <= acc + ftw_act (ACC_W+1-bit sum), carry_d <= c.
  - else: acc holds, carry_d <= 0.
  - en_d <= en in all non-reset cases.
- Stage 2 (offset):
  - phase_out <= acc + pofs_act, truncated to ACC_W.
  - phase_valid <= en_d.
  - wrap <= carry_d.
  - Stage 2 updates every edge, so phase_out tracks offset changes even when en=0.
- Latency: an increment launched with en at edge k appears on phase_out at edge k+1, with phase_valid=1 in the cycle after edge k+1.
- FTW double buffer:
  - ftw_load at edge k: ftw_pend <= ftw_in, ftw_pending <= 1.
  - UPDATE_ON_WRAP=0: at edge k+1, ftw_act <= ftw_pend and ftw_pending <= 0. The addition at edge k+1 still uses the old FTW; edge k+2 uses the new one.
  - UPDATE_ON_WRAP=1: commit occurs at the first edge where en=1, sync=0 and the addition carries out. That addition used the old FTW. sync=1 also commits immediately, so an FTW of 0 cannot deadlock the update.
  - Load on the same edge as a commit: ftw_pend takes the new value and ftw_pending stays 1. The newest load always wins.
  - rst discards any pending FTW.
- Offset: pofs_load at edge k sets pofs_act <= pofs_in. phase_out reflects the new offset from edge k+1. No buffering.
- Arithmetic is unsigned modulo 2^ACC_W, with no saturation. wrap is carry-out of the FTW addition only; the offset addition never sets wrap.
- rst mid-operation clears the pipeline: phase_valid = 0 in the cycle following the reset edge.

Test Plan:
- Reset, then FTW=65536 loaded, en=1 → phase_out = 65536, 131072, 196608 on successive edges. phase_valid=1. Upper 16 bits give 1, 2, 3.
- FTW=0x8000_0000, en=1 → phase_out = 0x8000_0000, then 0x0000_0000 with wrap=1, then 0x8000_0000 with wrap=0.
- After 4 increments with FTW=100, assert pofs_load with 0x0001_0000 → next phase_out = 0x0001_0000+400. Then sync=1 → acc=0 and phase_out = 0x0001_0000 one edge later.
- UPDATE_ON_WRAP=1, FTW=0x4000_0000, load 0x1000_0000 at acc=0x4000_0000:
  - ftw_pending stays 1 through acc 0x8000_0000 and 0xC000_0000.
  - Commit at the wrap to 0.
  - Next step is 0x1000_0000.
- en toggled 1,0,0,1 → acc holds during en=0. phase_valid follows en delayed by 1. wrap=0 while held.
- Back-to-back ftw_load of 10 then 20 on consecutive edges → ftw_pending stays 1 across both. Final ftw_act=20; the value 10 is used for exactly one addition when en=1.
